// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_pkg
// Description : Shared types and constants for the asynchronous SRAM
//               controller: FSM state encoding and wait-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

  // Width of the per-access strobe down-counter (WAIT_STATES up to 15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } sram_state_e;

endpackage : sram_pkg
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller
// Description : Single-port bus master to asynchronous 16-bit SRAM bridge.
//               Each request is latched in IDLE, the SRAM is strobed for
//               WAIT_STATES cycles (ACCESS), then a one-cycle ACK follows.
//               All SRAM-side outputs and m_ack come straight from flops.
// Ports       :
//   clk, reset                 clock; asynchronous active-high reset
//   m_addr[19:1]               word address from master
//   m_data_out / m_data_in     write data from / read data to master
//   m_access, m_wr_en          request (held until ack), write select
//   m_bytesel[1:0]             byte enables (bit1 upper, bit0 lower)
//   m_ack                      single-cycle completion pulse
//   sram_addr, sram_dq_*       SRAM address and split data bus + enable
//   sram_ce/oe/we/ub/lb_n      active-low SRAM strobes
// Revision    : 1.0 - initial release
// ============================================================================
module sram_controller
  import sram_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] m_addr,
  input  logic [15:0] m_data_out,
  output logic [15:0] m_data_in,
  input  logic        m_access,
  input  logic        m_wr_en,
  input  logic [1:0]  m_bytesel,
  output logic        m_ack,
  output logic [18:0] sram_addr,
  input  logic [15:0] sram_dq_in,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  // Counter is loaded with WAIT_STATES-1 so ACCESS lasts WAIT_STATES cycles.
  localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(WAIT_STATES - 1);

  sram_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wr;
  logic [15:0]      r_rdata;
  logic             r_ack;
  logic [18:0]      r_addr;
  logic [15:0]      r_dq_out;
  logic             r_dq_oe;
  logic             r_ce_n;
  logic             r_oe_n;
  logic             r_we_n;
  logic             r_ub_n;
  logic             r_lb_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_wr     <= 1'b0;
      r_rdata  <= '0;
      r_ack    <= 1'b0;
      r_addr   <= '0;
      r_dq_out <= '0;
      r_dq_oe  <= 1'b0;
      r_ce_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_ub_n   <= 1'b1;
      r_lb_n   <= 1'b1;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (m_access) begin
            // Latch the whole request; strobes go active on this same edge
            // so the first ACCESS cycle already presents them.
            r_state  <= ST_ACCESS;
            r_cnt    <= c_CNT_LOAD;
            r_wr     <= m_wr_en;
            r_addr   <= m_addr;
            r_dq_out <= m_data_out;
            r_dq_oe  <= m_wr_en;
            r_ce_n   <= 1'b0;
            r_oe_n   <= m_wr_en;
            r_we_n   <= ~m_wr_en;
            r_ub_n   <= ~m_bytesel[1];
            r_lb_n   <= ~m_bytesel[0];
          end
        end

        ST_ACCESS: begin
          if (r_cnt == '0) begin
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            if (r_wr) begin
              // Keep chip enable and data driven one extra cycle so the
              // data is held after the rising edge of we_n.
              r_ce_n <= 1'b0;
            end else begin
              r_rdata <= sram_dq_in;
              r_ce_n  <= 1'b1;
              r_ub_n  <= 1'b1;
              r_lb_n  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        ST_ACK: begin
          r_state <= ST_IDLE;
          r_ce_n  <= 1'b1;
          r_ub_n  <= 1'b1;
          r_lb_n  <= 1'b1;
          r_dq_oe <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_data_in   = r_rdata;
  assign m_ack       = r_ack;
  assign sram_addr   = r_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_ce_n   = r_ce_n;
  assign sram_oe_n   = r_oe_n;
  assign sram_we_n   = r_we_n;
  assign sram_ub_n   = r_ub_n;
  assign sram_lb_n   = r_lb_n;

endmodule : sram_controller
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_controller
// Description : Directed self-checking bench for sram_controller. A second
//               instance with WAIT_STATES=1 covers the short-latency case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:1] m_addr = '0;
  logic [15:0] m_data_out = '0;
  logic        m_access = 1'b0;
  logic        m_access1 = 1'b0;
  logic        m_wr_en = 1'b0;
  logic [1:0]  m_bytesel = 2'b11;

  logic [15:0] m_data_in, sram_dq_in, sram_dq_out;
  logic [18:0] sram_addr;
  logic        m_ack, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  logic [15:0] m_data_in1, sram_dq_in1, sram_dq_out1;
  logic [18:0] sram_addr1;
  logic        m_ack1, sram_dq_oe1, sram_ce_n1, sram_oe_n1, sram_we_n1, sram_ub_n1, sram_lb_n1;

  int total = 0;
  int bad = 0;

  wire [4:0] strb = {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n};

  // SRAM contents: one fixed word, everything else derived from address.
  function automatic logic [15:0] mem(input logic [18:0] a);
    if (a == 19'h12345) return 16'hBEEF;
    return 16'h1234 ^ a[15:0];
  endfunction

  assign sram_dq_in  = mem(sram_addr);
  assign sram_dq_in1 = mem(sram_addr1);

  always #5 clk = ~clk;

  sram_controller #(.WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .m_addr(m_addr), .m_data_out(m_data_out),
    .m_data_in(m_data_in), .m_access(m_access), .m_wr_en(m_wr_en),
    .m_bytesel(m_bytesel), .m_ack(m_ack), .sram_addr(sram_addr),
    .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  sram_controller #(.WAIT_STATES(1)) dut1 (
    .clk(clk), .reset(reset), .m_addr(m_addr), .m_data_out(m_data_out),
    .m_data_in(m_data_in1), .m_access(m_access1), .m_wr_en(m_wr_en),
    .m_bytesel(m_bytesel), .m_ack(m_ack1), .sram_addr(sram_addr1),
    .sram_dq_in(sram_dq_in1), .sram_dq_out(sram_dq_out1), .sram_dq_oe(sram_dq_oe1),
    .sram_ce_n(sram_ce_n1), .sram_oe_n(sram_oe_n1), .sram_we_n(sram_we_n1),
    .sram_ub_n(sram_ub_n1), .sram_lb_n(sram_lb_n1)
  );

  // Bus contention guard: never drive data while the SRAM drives it.
  always @(negedge clk) begin
    total++;
    if ((sram_dq_oe && !sram_oe_n) || (sram_dq_oe1 && !sram_oe_n1)) begin
      bad++;
      $display("FAIL bus_conflict t=%0t oe_n=%b dq_oe=%b oe_n1=%b dq_oe1=%b",
               $time, sram_oe_n, sram_dq_oe, sram_oe_n1, sram_dq_oe1);
    end
  end

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if (m_ack !== 1'b0 || m_data_in !== 16'h0) begin
      bad++; $display("FAIL reset_master ack=%b data=%h want 0/0000", m_ack, m_data_in);
    end
    total++;
    if (sram_addr !== 19'h0 || sram_dq_out !== 16'h0 || sram_dq_oe !== 1'b0) begin
      bad++; $display("FAIL reset_sram addr=%h dq_out=%h dq_oe=%b want 0", sram_addr, sram_dq_out, sram_dq_oe);
    end
    total++;
    if (strb !== 5'b11111) begin
      bad++; $display("FAIL reset_strobes got=%b want 11111", strb);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    m_addr = 19'h12345; m_wr_en = 1'b0; m_bytesel = 2'b11; m_access = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k <= 2) begin
        total++;
        if (strb !== 5'b00100 || sram_addr !== 19'h12345 || m_ack !== 1'b0 || sram_dq_oe !== 1'b0) begin
          bad++; $display("FAIL read_access k=%0d strb=%b addr=%h ack=%b dq_oe=%b want 00100/12345/0/0",
                          k, strb, sram_addr, m_ack, sram_dq_oe);
        end
      end else if (k == 3) begin
        total++;
        if (m_ack !== 1'b1 || m_data_in !== 16'hBEEF || strb !== 5'b11111) begin
          bad++; $display("FAIL read_ack ack=%b data=%h strb=%b want 1/beef/11111", m_ack, m_data_in, strb);
        end
        m_access = 1'b0;
      end else begin
        total++;
        if (m_ack !== 1'b0 || m_data_in !== 16'hBEEF) begin
          bad++; $display("FAIL read_after ack=%b data=%h want 0/beef", m_ack, m_data_in);
        end
      end
    end
  endtask

  task automatic test_write();
    m_addr = 19'h00010; m_data_out = 16'hA55A; m_wr_en = 1'b1; m_bytesel = 2'b01; m_access = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Master changes its bus after acceptance; must be ignored.
        m_addr = 19'h7FFFF; m_data_out = 16'h0000; m_wr_en = 1'b0; m_bytesel = 2'b10;
      end
      if (k <= 2) begin
        total++;
        if (strb !== 5'b01010 || sram_dq_oe !== 1'b1 || sram_dq_out !== 16'hA55A ||
            sram_addr !== 19'h00010 || m_ack !== 1'b0) begin
          bad++; $display("FAIL write_access k=%0d strb=%b dq_oe=%b dq=%h addr=%h ack=%b want 01010/1/a55a/00010/0",
                          k, strb, sram_dq_oe, sram_dq_out, sram_addr, m_ack);
        end
      end else if (k == 3) begin
        total++;
        if (m_ack !== 1'b1 || strb[4:2] !== 3'b011 || sram_dq_oe !== 1'b1 || sram_dq_out !== 16'hA55A) begin
          bad++; $display("FAIL write_ack ack=%b ce/oe/we=%b dq_oe=%b dq=%h want 1/011/1/a55a",
                          m_ack, strb[4:2], sram_dq_oe, sram_dq_out);
        end
        total++;
        if (m_data_in !== 16'hBEEF) begin
          bad++; $display("FAIL write_keeps_rdata got=%h want beef", m_data_in);
        end
        m_access = 1'b0;
      end else begin
        total++;
        if (m_ack !== 1'b0 || sram_ce_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
          bad++; $display("FAIL write_after ack=%b ce_n=%b dq_oe=%b want 0/1/0", m_ack, sram_ce_n, sram_dq_oe);
        end
      end
    end
  endtask

  task automatic test_addr_hold();
    m_addr = 19'h00ABC; m_wr_en = 1'b0; m_bytesel = 2'b11; m_access = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) m_addr = 19'h7FFFF;
      if (k <= 2) begin
        total++;
        if (sram_addr !== 19'h00ABC) begin
          bad++; $display("FAIL addr_hold k=%0d got=%h want 00abc", k, sram_addr);
        end
      end else begin
        total++;
        if (m_ack !== 1'b1 || m_data_in !== 16'h1888) begin
          bad++; $display("FAIL addr_hold_ack ack=%b data=%h want 1/1888", m_ack, m_data_in);
        end
        m_access = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    m_addr = 19'h00100; m_wr_en = 1'b0; m_bytesel = 2'b11; m_access = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 3) begin
        total++;
        if (m_ack !== 1'b1 || m_data_in !== 16'h1334) begin
          bad++; $display("FAIL b2b_ack1 ack=%b data=%h want 1/1334", m_ack, m_data_in);
        end
        m_addr = 19'h00200; m_data_out = 16'h1111; m_wr_en = 1'b1;
      end else if (k == 4) begin
        total++;
        if (m_ack !== 1'b0 || sram_ce_n !== 1'b1) begin
          bad++; $display("FAIL b2b_idle ack=%b ce_n=%b want 0/1", m_ack, sram_ce_n);
        end
      end else if (k == 5) begin
        total++;
        if (sram_addr !== 19'h00200 || sram_we_n !== 1'b0 || sram_dq_out !== 16'h1111) begin
          bad++; $display("FAIL b2b_second addr=%h we_n=%b dq=%h want 00200/0/1111", sram_addr, sram_we_n, sram_dq_out);
        end
      end else if (k == 7) begin
        total++;
        if (m_ack !== 1'b1 || m_data_in !== 16'h1334) begin
          bad++; $display("FAIL b2b_ack2 ack=%b data=%h want 1/1334", m_ack, m_data_in);
        end
        m_access = 1'b0;
      end else if (k != 8) begin
        total++;
        if (m_ack !== 1'b0) begin
          bad++; $display("FAIL b2b_noack k=%0d ack=%b want 0", k, m_ack);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    m_addr = 19'h00300; m_data_out = 16'h2222; m_wr_en = 1'b1; m_bytesel = 2'b11; m_access = 1'b1;
    @(negedge clk);
    total++;
    if (sram_we_n !== 1'b0) begin
      bad++; $display("FAIL rstmid_pre we_n=%b want 0", sram_we_n);
    end
    reset = 1'b1;
    #1;
    total++;
    if (sram_we_n !== 1'b1 || sram_ce_n !== 1'b1 || sram_dq_oe !== 1'b0 || m_ack !== 1'b0 || m_data_in !== 16'h0) begin
      bad++; $display("FAIL rstmid_async we_n=%b ce_n=%b dq_oe=%b ack=%b data=%h want 1/1/0/0/0000",
                      sram_we_n, sram_ce_n, sram_dq_oe, m_ack, m_data_in);
    end
    m_access = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (m_ack !== 1'b0) begin
        bad++; $display("FAIL rstmid_noack ack=%b want 0", m_ack);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (m_ack !== 1'b0 || sram_ce_n !== 1'b1) begin
      bad++; $display("FAIL rstmid_release ack=%b ce_n=%b want 0/1", m_ack, sram_ce_n);
    end
    m_addr = 19'h00400; m_wr_en = 1'b0; m_access = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (m_ack !== 1'b1 || m_data_in !== 16'h1634) begin
      bad++; $display("FAIL rstmid_read ack=%b data=%h want 1/1634", m_ack, m_data_in);
    end
    m_access = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bytesel0();
    m_addr = 19'h00005; m_wr_en = 1'b0; m_bytesel = 2'b00; m_access = 1'b1;
    @(negedge clk);
    total++;
    if (strb !== 5'b00111) begin
      bad++; $display("FAIL bytesel0_strb got=%b want 00111", strb);
    end
    repeat (2) @(negedge clk);
    total++;
    if (m_ack !== 1'b1 || m_data_in !== 16'h1231) begin
      bad++; $display("FAIL bytesel0_ack ack=%b data=%h want 1/1231", m_ack, m_data_in);
    end
    m_access = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ws1();
    m_addr = 19'h12345; m_wr_en = 1'b0; m_bytesel = 2'b11; m_access1 = 1'b1;
    @(negedge clk);
    total++;
    if (sram_oe_n1 !== 1'b0 || m_ack1 !== 1'b0) begin
      bad++; $display("FAIL ws1_access oe_n=%b ack=%b want 0/0", sram_oe_n1, m_ack1);
    end
    @(negedge clk);
    total++;
    if (m_ack1 !== 1'b1 || m_data_in1 !== 16'hBEEF) begin
      bad++; $display("FAIL ws1_ack ack=%b data=%h want 1/beef", m_ack1, m_data_in1);
    end
    m_access1 = 1'b0;
    @(negedge clk);
    total++;
    if (m_ack1 !== 1'b0) begin
      bad++; $display("FAIL ws1_single_pulse ack=%b want 0", m_ack1);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_addr_hold();
    test_back_to_back();
    test_reset_mid();
    test_bytesel0();
    test_ws1();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sram_controller
`default_nettype wire

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter: WAIT_STATES, 2, SRAM strobe cycles per access (legal range 1..15).
REQ-002 SHALL have ports: clk input 1 clock; reset input 1 asynchronous, active-high reset.
REQ-003 SHALL have port: m_addr input 19 [19:1] word address from bus master.
REQ-004 SHALL have port: m_data_out input 16 write data from master.
REQ-005 SHALL have port: m_data_in output 16 read data to master.
REQ-006 SHALL have ports: m_access input 1 request, held until ack; m_wr_en input 1 write when high; m_bytesel input 2 byte enables, bit1 = upper, bit0 = lower.
REQ-007 SHALL have port: m_ack output 1 single-cycle completion pulse.
REQ-008 SHALL have ports: sram_addr output 19 address; sram_dq_in input 16 data from SRAM; sram_dq_out output 16 data to SRAM; sram_dq_oe output 1 data driver enable.
REQ-009 SHALL have ports: sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n output 1 each, active-low strobes.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, ACK; IDLE->ACCESS on m_access=1; ACCESS->ACK after exactly WAIT_STATES cycles; ACK->IDLE unconditionally.
REQ-011 SHALL latch m_addr, m_data_out, m_wr_en and m_bytesel on the IDLE cycle where m_access=1; later changes on m_* until ACK SHALL be ignored.
REQ-012 SHALL drive all SRAM outputs from registers (glitch-free).
REQ-013 ACCESS: sram_ce_n=0; sram_ub_n=~bytesel[1]; sram_lb_n=~bytesel[0]; sram_addr=latched address.
REQ-014 Read: sram_oe_n=0 throughout ACCESS; sram_dq_in captured into read register on final ACCESS clock edge.
REQ-015 Write: sram_we_n=0 throughout ACCESS; sram_dq_oe=1 and sram_dq_out=latched data in ACCESS and ACK (one cycle of data hold after we_n rises).
REQ-016 ACK: m_ack=1 for exactly one cycle; sram_ce_n=0 held for write hold, otherwise 1; oe_n, we_n high.
REQ-017 m_data_in SHALL equal read register; valid in read ACK cycle; held until next read capture; writes leave it unchanged.
REQ-018 Latency: request accepted in cycle N -> m_ack in cycle N+1+WAIT_STATES; the earliest next accept is the cycle after ACK (throughput one per WAIT_STATES+2 cycles).
REQ-019 m_access still high in the cycle after ACK SHALL be treated as a new request.
REQ-020 m_access dropping mid-transaction (protocol violation) SHALL NOT abort; transaction completes and acks.
REQ-021 bytesel=2'b00 SHALL perform a full cycle with both byte strobes high and ack normally.
REQ-022 sram_dq_oe SHALL never be 1 while sram_oe_n=0.

Reset
REQ-023 Reset SHALL force IDLE immediately (asynchronous), aborting any transaction without m_ack.
REQ-024 Reset values: m_ack=0, m_data_in=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, all *_n strobes=1.

Structure
REQ-025 Shared package sram_pkg SHALL hold the state enum typedef and wait-counter width constant (4 bits).
REQ-026 SHALL be a single flat module with no sub-module; the wait counter is an in-module down-counter.

Verification (WAIT_STATES=2 unless stated)
REQ-027 Read: addr 19'h12345 at N, model returns 16'hBEEF -> oe_n low N+1..N+2, m_ack at N+3, m_data_in=16'hBEEF.
REQ-028 Write: 16'hA55A, bytesel 2'b01, addr 19'h00010 -> we_n low N+1..N+2, lb_n=0, ub_n=1, dq_oe high N+1..N+3, m_ack at N+3.
REQ-029 Back-to-back: read then write with m_access held -> acks at N+3 and N+7, second address presented N+5.
REQ-030 Reset asserted mid-ACCESS of write -> we_n, ce_n=1 and dq_oe=0 before the next edge, no m_ack; after release, a new read completes normally.
REQ-031 m_addr changed to 19'h7FFFF after accept -> sram_addr stays at the latched value until ACK.
REQ-032 WAIT_STATES=1 read -> m_ack at N+2 with correct data.
